// File: rtl/uart8transmitter.sv
// 8N1 UART transmitter: LSB-first serialiser fed from a small byte FIFO.
// Frames can be issued back-to-back with no idle cycle between stop and start bits.
module uart8transmitter #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned BAUD_DIV   = CLOCK_FREQ / BAUD_RATE,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int unsigned CNT_W  = $clog2(BAUD_DIV);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   baud_cnt, baud_cnt_d;
  logic [2:0]         bit_idx, bit_idx_d;
  logic [7:0]         shift, shift_d;
  logic               tx_d;
  logic               baud_done;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]  count;
  logic               push, pop;
  logic               fifo_nonempty;
  logic [7:0]         head;

  assign tx_ready      = (count != FIFO_FULL);
  assign push          = tx_valid && tx_ready && !reset;
  assign fifo_nonempty = (count != FCNT_W'(0));
  assign head          = mem[rd_ptr];
  assign baud_done     = (baud_cnt == BAUD_LAST);

  // FIFO storage; stale entries are harmless because pointers are reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + FCNT_W'(push) - FCNT_W'(pop);
    end
  end

  // FSM state and registered line outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      tx       <= tx_d;
      tx_busy  <= (state_d != IDLE);
    end
  end

  // Next-state logic; the head byte is popped on every frame-start decision
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    tx_d       = tx;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop        = 1'b1;
          shift_d    = head;
          tx_d       = 1'b0;
          baud_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_done) begin
          tx_d       = shift[0];
          bit_idx_d  = '0;
          baud_cnt_d = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = shift >> 1;
            tx_d      = shift[1];
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart8transmitter.sv
// Bench for uart8transmitter: a cycle-level line model (byte queue expanded into
// per-cycle line levels) checks a BAUD_DIV=10 instance; a mid-bit sampler checks defaults.
module tb_uart8transmitter;

  localparam int D     = 10;
  localparam int DEPTH = 4;
  localparam int DD    = 434;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready, tx, busy;
  logic [7:0] d_data;
  logic       d_valid;
  logic       d_ready, d_tx, d_busy;

  uart8transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(rst), .tx_data(data), .tx_valid(valid),
    .tx_ready(ready), .tx(tx), .tx_busy(busy)
  );

  uart8transmitter u_def (
    .clk(clk), .reset(rst), .tx_data(d_data), .tx_valid(d_valid),
    .tx_ready(d_ready), .tx(d_tx), .tx_busy(d_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int off    = 0;

  logic [7:0] mq[$];
  logic       lq[$];
  logic       exp_tx, exp_busy;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  // Expand one byte into the line levels seen after each clock edge of its frame
  task automatic frame(input logic [7:0] b);
    logic v;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = 1'b1;
      else             v = b[i-1];
      repeat (D) lq.push_back(v);
    end
  endtask

  // Advance one clock, update the model with the inputs seen at that edge, compare
  task automatic tick();
    logic       cv, cr;
    logic [7:0] cd;
    int         sz;
    cv = valid; cr = rst; cd = data;
    @(posedge clk); #1;
    cyc++;
    if (cr) begin
      mq.delete(); lq.delete();
      exp_tx = 1'b1; exp_busy = 1'b0;
    end else begin
      sz = mq.size();
      if (lq.size() != 0) begin
        exp_tx = lq.pop_front(); exp_busy = 1'b1;
      end else if (sz != 0) begin
        frame(mq.pop_front());
        exp_tx = lq.pop_front(); exp_busy = 1'b1;
      end else begin
        exp_tx = 1'b1; exp_busy = 1'b0;
      end
      if (cv && sz != DEPTH) mq.push_back(cd);
    end
    check("tx", 8'(tx), 8'(exp_tx));
    check("tx_busy", 8'(busy), 8'(exp_busy));
    check("tx_ready", 8'(ready), 8'(mq.size() != DEPTH));
  endtask

  task automatic adv(input int target);
    while (off < target) begin
      tick();
      off++;
    end
  endtask

  initial begin
    logic [7:0] dv [3];
    logic [7:0] seq [6];
    logic [7:0] rxb;
    int         base;

    // Reset with a pending push that must be ignored
    rst = 1'b1; valid = 1'b1; data = 8'hFF; d_valid = 1'b0; d_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0; valid = 1'b0;
    repeat (20) tick();

    // Single byte
    valid = 1'b1; data = 8'hA5; tick();
    valid = 1'b0;
    repeat (110) tick();

    // Fill and stream, sixth push arrives while full
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
    seq[3] = 8'h0F; seq[4] = 8'h3C; seq[5] = 8'h99;
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1; data = seq[i]; tick();
    end
    valid = 1'b0;
    repeat (520) tick();

    // Push coinciding with the stop-to-start pop
    valid = 1'b1; data = 8'h12; tick();
    data = 8'h34; tick();
    valid = 1'b0;
    while (lq.size() != 0) tick();
    valid = 1'b1; data = 8'h56; tick();
    valid = 1'b0;
    repeat (320) tick();

    // Reset in the middle of a frame with a second byte still queued
    valid = 1'b1; data = 8'hA5; tick();
    data = 8'h11; tick();
    valid = 1'b0;
    repeat (34) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (50) tick();
    valid = 1'b1; data = 8'h3C; tick();
    valid = 1'b0;
    repeat (110) tick();

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 99) < 4);
      data  = 8'($urandom);
      rst   = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; valid = 1'b0;
    repeat (600) tick();

    // Default parameters: three back-to-back frames decoded by mid-bit sampling
    dv[0] = 8'h00; dv[1] = 8'h7E; dv[2] = 8'hFF;
    d_valid = 1'b1; d_data = dv[0]; tick();
    d_data = dv[1]; tick();
    check("d_fall", 8'(d_tx), 8'h00);
    d_data = dv[2]; tick();
    d_valid = 1'b0;
    off = 1;
    for (int k = 0; k < 3; k++) begin
      base = k * 10 * DD;
      if (k > 0) begin
        adv(base - 1);
        check("d_stop_end", 8'(d_tx), 8'h01);
        adv(base);
        check("d_fall", 8'(d_tx), 8'h00);
      end
      adv(base + 10);
      check("d_busy", 8'(d_busy), 8'h01);
      adv(base + DD - 1);
      check("d_start_end", 8'(d_tx), 8'h00);
      adv(base + DD);
      check("d_bit0_begin", 8'(d_tx), 8'(dv[k][0]));
      rxb = 8'h00;
      for (int i = 0; i < 8; i++) begin
        adv(base + DD * (i + 1) + DD / 2);
        rxb[i] = d_tx;
      end
      check("d_byte", rxb, dv[k]);
      adv(base + DD * 9 + DD / 2);
      check("d_stop", 8'(d_tx), 8'h01);
    end
    adv(3 * 10 * DD + 5);
    check("d_idle_tx", 8'(d_tx), 8'h01);
    check("d_idle_busy", 8'(d_busy), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart8transmitter.md
# uart8transmitter

8N1 UART transmitter: it serialises bytes from a parallel valid/ready stream onto the `tx` line. LSB first, one start bit, eight data bits, one stop bit, no parity. It sits beside `uart8receiver` in the same clock domain and uses the same baud-divider arithmetic, so a looped-back `tx` → `rx` pair interoperates. A small FIFO decouples the byte producer so that frames can go out back-to-back with no idle gap.

## Interface
- `CLOCK_FREQ`, 50000000: input clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `BAUD_DIV`, `CLOCK_FREQ/BAUD_RATE` (integer division, 434 by default): clocks per bit. Must be ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO depth. Power of two, ≥ 2.
- `clk`  in  1  system clock. All logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send. Sampled when `tx_valid && tx_ready`.
- `tx_valid`  in  1  producer has a byte on `tx_data`.
- `tx_ready`  out  1  FIFO can accept a byte. Equals `count != FIFO_DEPTH`, combinational from the registered count.
- `tx`  out  1  serial line, registered. Idle level is 1.
- `tx_busy`  out  1  registered. High while a frame is on the line (state != IDLE).

## Operation
- **Reset.** Applies at any time, including mid-frame. At the next edge:
  - `tx` = 1, `tx_busy` = 0.
  - state = IDLE, baud counter = 0, bit index = 0.
  - FIFO read/write pointers and count = 0, so `tx_ready` = 1.
  - Any partial frame is abandoned.
  - `tx_valid` is ignored while `reset` is high.
- **FIFO push.** When `tx_valid && tx_ready`, `tx_data` is written at the write pointer. Pointers wrap modulo `FIFO_DEPTH`. Count width is clog2(`FIFO_DEPTH`)+1.
- **FIFO pop.** Taken only on a frame-start decision (see below). A push and a pop on the same edge leave count unchanged; both pointers advance.
- **Push when full.** `tx_ready` = 0, so the push is not accepted. FIFO contents are unchanged and the byte is lost to the producer unless it holds `tx_valid`.
- **FSM: IDLE, START, DATA, STOP.** The baud counter counts 0..`BAUD_DIV`-1, and each line bit is held exactly `BAUD_DIV` clocks.
- **IDLE.** `tx` = 1. If count > 0: pop the head into the shift register, set `tx` <= 0, baud counter <= 0, go to START.
- **START.** When the baud counter reaches `BAUD_DIV`-1: `tx` <= shift[0], bit index <= 0, go to DATA. Otherwise increment the counter.
- **DATA.** When the counter reaches `BAUD_DIV`-1:
  - If bit index = 7: `tx` <= 1 and go to STOP.
  - Otherwise: shift right, `tx` <= next bit, increment bit index.
- **STOP.** When the counter reaches `BAUD_DIV`-1:
  - If count > 0: pop, `tx` <= 0, go to START. Back-to-back frames have no idle cycle.
  - Otherwise: go to IDLE.
- **Counter width.** The baud counter is clog2(`BAUD_DIV`) bits. It never exceeds `BAUD_DIV`-1.

## Timing
- **Latency.** A byte accepted at edge k into an empty FIFO, with the FSM in IDLE, gives count = 1 after edge k. `tx` falls at edge k+1.
- **Frame length.** Exactly 10·`BAUD_DIV` clocks from the falling edge of the start bit to the end of the stop bit.
- **`tx_busy`.** Rises at the edge where `tx` falls. It falls at the edge ending the stop bit, unless the next frame starts on that edge.
- **`tx_ready` after a pop.** Rises in the cycle after a pop frees a slot in a full FIFO.
- **Sustained throughput.** One byte per 10·`BAUD_DIV` clocks.

## Test plan
Tests 1–5 use `CLOCK_FREQ`=1000, `BAUD_RATE`=100 (`BAUD_DIV`=10), `FIFO_DEPTH`=4.
1. **Reset values.** Hold `reset` high for 3 cycles with `tx_valid`=1, `tx_data`=0xFF → `tx`=1, `tx_busy`=0, `tx_ready`=1. After release nothing is transmitted.
2. **Single byte.** Push 0xA5 once from idle → `tx` falls 1 cycle later. The line carries 0,1,0,1,0,0,1,0,1,1, each level exactly 10 cycles. `tx_busy` is high for 100 cycles, then the line idles at 1.
3. **Fill and stream.** Push 0x00, 0xFF, 0x55, 0x0F, 0x3C on 5 consecutive cycles → count reaches 4 and `tx_ready`=0. A 6th push of 0x99 is held off. All five frames go out contiguously in 500 cycles with no idle cycle between stop and start bits. `tx_ready` returns to 1 when the first STOP→START pop occurs.
4. **Simultaneous push/pop.** FIFO holds 1 byte at the end of a stop bit and a push arrives on the same edge → count stays 1, and both bytes are sent in order.
5. **Reset mid-frame.** Assert `reset` for 1 cycle at cycle 35 of a 0xA5 frame → `tx`=1 and `tx_busy`=0 after that edge, and the FIFO is empty. A later push of 0x3C is transmitted correctly.
6. **Default parameters, loopback.** Connect `tx` to `uart8receiver.rx` and send 0x00, 0x7E, 0xFF → each bit lasts 434 cycles and the receiver reports the same three bytes.
